instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
//  Fetch stage upstream of the single-instruction execute datapath. Owns the fetch PC,
//  issues word reads to the synchronous program memory, buffers returned words with
//  their PC in a small FIFO, and hands {instruction, pc} to execute via valid/ready.
//  A redirect input (taken JAL target from the PC-source mux) flushes the queue.
// PARAMETERS
//  PROGRAM_MEMORY_SIZE_WORDS  64   words in program memory; power of 2
//  FETCH_QUEUE_DEPTH          4    FIFO entries; power of 2, >=2
//  RESET_PC                   0    first fetch address after reset; word aligned
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  mem_req          out  1   read request to program memory this cycle
//  mem_addr         out  $clog2(PROGRAM_MEMORY_SIZE_WORDS)  word index = (pc>>2) mod size
//  mem_rdata        in   32  read data, valid exactly 1 cycle after mem_req
//  redirect_valid   in   1   flush and restart fetch at redirect_pc
//  redirect_pc      in   32  new fetch byte address; bits [1:0] ignored (treated 00)
//  out_valid        out  1   out_instruction/out_pc hold a valid entry
//  out_ready        in   1   execute accepts the entry this cycle
//  out_instruction  out  32  fetched instruction word
//  out_pc           out  32  byte address of out_instruction
// BEHAVIOUR
//  - Reset (reset=0): fetch_pc=RESET_PC, queue empty, in-flight flag clear,
//    mem_req=0, out_valid=0, out_instruction=0, out_pc=0. Asynchronous assert.
//  - FSM: WAIT (1st cycle after reset release, no request) -> RUN. RUN is permanent.
//  - Credit: mem_req=1 in RUN when occupancy + inflight < FETCH_QUEUE_DEPTH and
//    redirect_valid=0. On request: fetch_pc += 4 (mod 2^32), tag pc registered.
//  - Response: cycle after mem_req, {mem_rdata, tag pc} pushed into FIFO unless killed.
//  - Pop on out_valid & out_ready; push and pop same cycle keeps occupancy.
//  - Full: no request issued; occupancy never exceeds DEPTH, no entry ever dropped.
//  - Empty: out_valid=0; out_instruction/out_pc hold last value (don't-care).
//  - Redirect: same cycle, any handshake still completes (that entry is the JAL).
//    Next edge: FIFO cleared, fetch_pc=redirect_pc&~3, in-flight response killed
//    (discarded when it arrives). Following cycle: mem_req with new address.
//    Redirect wins over a same-cycle push. Back-to-back redirects: last one wins.
//  - Latency: redirect -> request 1 cycle; request -> out_valid see CONFIGURATION.
//  - Address wrap: fetch_pc 0xFFFFFFFC + 4 = 0; mem_addr wraps modulo memory size.
//  - Reset mid-stream: all state cleared immediately, resumes at RESET_PC via WAIT.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined: when FIFO empty (or popping its last entry
//    impossible-to-skip ordering preserved), live response drives out_* same cycle
//    it arrives; accepted if out_ready, else written to FIFO. Request->out_valid = 1.
//  Not defined: every response goes through FIFO; request->out_valid = 2 cycles.
//  Ordering and flush rules identical in both builds.
// TESTING
//  1 Reset release, out_ready=1, mem[i]=0x100+i: out_pc 0,4,8,... in order,
//    out_instruction 0x100,0x101,...; one word per cycle steady state.
//  2 out_ready=0 for 20 cycles: exactly DEPTH=4 requests issued, mem_req then 0;
//    release -> pcs 0,4,8,12,16 with no gap or duplicate.
//  3 Redirect to 0x20 while pc=8 in flight and 2 queued: none of the stale entries
//    appear; next out_pc=0x20, out_instruction=mem[8].
//  4 redirect_pc=0x23: mem_addr=8, out_pc=0x20.
//  5 Redirect to 0xFC with size 64: out_pc 0xFC,0x100 -> mem_addr 63 then 0.
//  6 Assert reset mid-stream with 3 entries: out_valid=0 same cycle; after release
//    first out_pc=RESET_PC; run both with and without FETCH_QUEUE_BYPASS_EN, check
//    first-output latency 1 vs 2 cycles after first mem_req.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads program memory and queues {instr, pc} for execute.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module instruction_fetch_queue #(
    parameter int          PROGRAM_MEMORY_SIZE_WORDS = 64,
    parameter int          FETCH_QUEUE_DEPTH         = 4,
    parameter logic [31:0] RESET_PC                  = 32'h0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    output logic                                         mem_req,
    output logic [$clog2(PROGRAM_MEMORY_SIZE_WORDS)-1:0] mem_addr,
    input  logic [31:0]                                  mem_rdata,
    input  logic                                         redirect_valid,
    input  logic [31:0]                                  redirect_pc,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [31:0]                                  out_instruction,
    output logic [31:0]                                  out_pc
);

    localparam int AW = $clog2(PROGRAM_MEMORY_SIZE_WORDS);
    localparam int PW = $clog2(FETCH_QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW:0]   DEPTH_V = FETCH_QUEUE_DEPTH;

    typedef enum logic {
        S_WAIT,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   q_instr [FETCH_QUEUE_DEPTH];
    logic [31:0]   q_pc    [FETCH_QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          credit;
    logic          empty;
    logic          bypass;
    logic          fire;
    logic          pop;
    logic          push;
    logic          unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    assign empty  = (count == '0);
    assign used   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign credit = (used < DEPTH_V);

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        case (state)
            S_WAIT: state_next = S_RUN;
            S_RUN:  mem_req    = credit & ~redirect_valid;
            default: state_next = S_WAIT;
        endcase
    end

    assign mem_addr = fetch_pc[AW+1:2];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & inflight;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid       = ~empty | bypass;
    assign out_instruction = bypass ? mem_rdata : q_instr[rd_ptr];
    assign out_pc          = bypass ? inflight_pc : q_pc[rd_ptr];

    assign fire = out_valid & out_ready;
    assign pop  = fire & ~empty;
    // A redirect discards the response arriving with it unless execute takes it live.
    assign push = inflight & ~redirect_valid & ~(bypass & out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_WAIT;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state    <= state_next;
            inflight <= mem_req;
            if (mem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FETCH_QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
